fifo_rd_ptr_ctrl: RTL

FIFO_RD_PTR_CTRL -- requirements
Module: fifo_rd_ptr_ctrl

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 29 ++
 rtl/fifo_rd_ptr_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer constants and Gray/binary conversion helpers.
// Latency: combinational helpers only; no state.
// Backpressure: not applicable; used by both read- and write-side pointer blocks.
package fifo_pkg;

    // Default FIFO address width; depth is 2**ADDR_WIDTH.
    localparam int ADDR_WIDTH_DEF = 4;

    // Pointers carry one extra MSB so full and empty can be told apart.
    localparam int PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;

    // Helpers work on a fixed wide vector; callers zero-extend and truncate.
    // Leading zeros do not change either conversion, so any narrower pointer
    // width gives the correct result in its low bits.
    localparam int FN_W = 32;

    // Binary to reflected Gray code.
    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary: each bit is the XOR of itself and all
    // more-significant Gray bits.
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray);
        logic [FN_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < FN_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing a Gray-coded bus into the local clock domain.
// Latency: two clk edges from input change to q_o.
// Backpressure: none; samples every edge.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back capture stages; both cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller of an async FIFO: read address, Gray pointer, empty/level flags.
// Latency: raddr/rptr_gray update on the edge of an accepted read; write-pointer changes reach empty/rd_count after two sync edges plus one.
// Backpressure: reads are accepted only while empty is low; a read while empty is dropped and latches underflow.
module fifo_rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wptr_gray_async,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  rd_valid,
    output logic                  underflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    // Write pointer as seen in the read domain.
    logic [PTR_W-1:0] wq2_wptr;
    logic [PTR_W-1:0] wbin_sync;

    // Registered read-side state and its next-state values.
    logic [PTR_W-1:0] rbin_q,      rbin_d;
    logic [PTR_W-1:0] rgray_q,     rgray_d;
    logic             empty_q,     empty_d;
    logic [PTR_W-1:0] rd_count_q,  rd_count_d;
    logic             rd_valid_q,  rd_valid_d;
    logic             underflow_q, underflow_d;

    logic             accepted;

    sync_2ff #(
        .WIDTH (PTR_W)
    ) u_wptr_sync (
        .clk (clk),
        .rst (rst),
        .d_i (wptr_gray_async),
        .q_o (wq2_wptr)
    );

    // Next-state logic: advance on accepted reads and recompare against the
    // synchronized write pointer using the post-read pointer, so a read and a
    // write-pointer update landing on the same edge are both accounted for.
    always_comb begin
        accepted    = rd_en && !empty_q;
        rbin_d      = rbin_q + PTR_W'(accepted);
        rgray_d     = PTR_W'(bin2gray(FN_W'(rbin_d)));
        wbin_sync   = PTR_W'(gray2bin(FN_W'(wq2_wptr)));
        empty_d     = (rgray_d == wq2_wptr);
        rd_count_d  = wbin_sync - rbin_d;
        rd_valid_d  = accepted;
        underflow_d = underflow_q || (rd_en && empty_q);
    end

    // State registers; reset leaves the FIFO looking empty until the
    // synchronizer has resampled the write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            rd_count_q  <= '0;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            empty_q     <= empty_d;
            rd_count_q  <= rd_count_d;
            rd_valid_q  <= rd_valid_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory address comes straight from the register; the low bits wrap
    // naturally and the extra MSB only serves full/empty discrimination.
    assign raddr        = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_gray    = rgray_q;
    assign empty        = empty_q;
    assign rd_count     = rd_count_q;
    assign almost_empty = (rd_count_q <= PTR_W'(1));
    assign rd_valid     = rd_valid_q;
    assign underflow    = underflow_q;

endmodule
